// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter family: saturation mode and count direction encodings.
package counter_pkg;

  localparam int   CNT_WRAP = 0;
  localparam int   CNT_SAT  = 1;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DN   = 1'b0;

endpackage : counter_pkg

// File: rtl/counter_step.sv
// Combinational next-count for one enabled step, with wrap or hold at the ends of 0..MODULUS-1.
// Latency: none. Backpressure: none; the caller decides whether the step is taken.
module counter_step
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int SATURATE = CNT_WRAP
) (
  input  logic [WIDTH-1:0] q,
  input  logic             d,
  output logic [WIDTH-1:0] nxt,
  output logic             at_term
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic at_hi;
  logic at_lo;

  // Explicit compare against MAX_VAL so non-power-of-two moduli wrap correctly.
  assign at_hi   = (q == MAX_VAL);
  assign at_lo   = (q == '0);
  assign at_term = ((d == DIR_UP) && at_hi) || ((d == DIR_DN) && at_lo);

  always_comb begin
    nxt = q;
    if (at_term) begin
      if (SATURATE == CNT_WRAP) begin
        nxt = (d == DIR_UP) ? '0 : MAX_VAL;
      end
    end else if (d == DIR_UP) begin
      nxt = q + 1'b1;
    end else begin
      nxt = q - 1'b1;
    end
  end

endmodule : counter_step

// File: rtl/updown_counter_mod.sv
// Modulo up/down counter with Clr > Pre > LOAD > E priority, sticky out-of-range flag and terminal flags.
// Latency: one cycle from any control to Q; flags follow Q combinationally. Backpressure: none.
module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MODULUS    = 256,
  parameter int SATURATE   = CNT_WRAP,
  parameter int PRESET_VAL = MODULUS - 1
) (
  input  logic             CLK,
  input  logic             Clr,
  input  logic             Pre,
  input  logic             LOAD,
  input  logic             E,
  input  logic             D,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] Q,
  output logic             TC_HI,
  output logic             TC_LO,
  output logic             CO,
  output logic             OVF
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] PRE_VAL = WIDTH'(PRESET_VAL);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("updown_counter_mod: MODULUS must lie in 2..2**WIDTH");
  end
  if (PRESET_VAL < 0 || PRESET_VAL >= MODULUS) begin : g_bad_preset
    $error("updown_counter_mod: PRESET_VAL must be below MODULUS");
  end
  if (SATURATE != CNT_WRAP && SATURATE != CNT_SAT) begin : g_bad_mode
    $error("updown_counter_mod: SATURATE must be 0 or 1");
  end

  logic [WIDTH-1:0] step_nxt;
  logic             step_term;
  logic             ovf_q;
  logic             ctrl_any;

  counter_step #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_step (
    .q       (Q),
    .d       (D),
    .nxt     (step_nxt),
    .at_term (step_term)
  );

  assign ctrl_any = Clr | Pre | LOAD;

  always_ff @(posedge CLK) begin
    if (Clr) begin
      Q     <= '0;
      ovf_q <= 1'b0;
    end else if (Pre) begin
      Q     <= PRE_VAL;
      ovf_q <= 1'b0;
    end else if (LOAD) begin
      // Out-of-range loads clamp to the top of the range and flag it.
      if (IN > MAX_VAL) begin
        Q     <= MAX_VAL;
        ovf_q <= 1'b1;
      end else begin
        Q     <= IN;
        ovf_q <= 1'b0;
      end
    end else if (E) begin
      Q <= step_nxt;
      if (step_term) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign TC_HI = (Q == MAX_VAL);
  assign TC_LO = (Q == '0);
  assign CO    = E & ~ctrl_any & step_term;
  assign OVF   = ovf_q;

endmodule : updown_counter_mod

// File: tb/tb_updown_counter_mod.sv
// Directed bench: wrap and saturate counters at MODULUS=10 plus a MODULUS=16 wrap counter, shared stimulus.
module tb_updown_counter_mod;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       pre = 1'b0;
  logic       load = 1'b0;
  logic       e = 1'b0;
  logic       d = 1'b1;
  logic [3:0] ld_val = '0;

  logic [3:0] q_w, q_s, q_m;
  logic       tc_hi_w, tc_lo_w, co_w, ovf_w;
  logic       tc_hi_s, tc_lo_s, co_s, ovf_s;
  logic       tc_hi_m, tc_lo_m, co_m, ovf_m;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap (
    .CLK(clk), .Clr(clr), .Pre(pre), .LOAD(load), .E(e), .D(d), .IN(ld_val),
    .Q(q_w), .TC_HI(tc_hi_w), .TC_LO(tc_lo_w), .CO(co_w), .OVF(ovf_w)
  );

  updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
    .CLK(clk), .Clr(clr), .Pre(pre), .LOAD(load), .E(e), .D(d), .IN(ld_val),
    .Q(q_s), .TC_HI(tc_hi_s), .TC_LO(tc_lo_s), .CO(co_s), .OVF(ovf_s)
  );

  updown_counter_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_m16 (
    .CLK(clk), .Clr(clr), .Pre(pre), .LOAD(load), .E(e), .D(d), .IN(ld_val),
    .Q(q_m), .TC_HI(tc_hi_m), .TC_LO(tc_lo_m), .CO(co_m), .OVF(ovf_m)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 1'b0; pre = 1'b0; load = 1'b0; e = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    total++; if (q_w !== 4'd0)   begin bad++; $display("FAIL reset_q got=%0d want=0", q_w); end
    total++; if (ovf_w !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf_w); end
    total++; if (tc_lo_w !== 1'b1) begin bad++; $display("FAIL reset_tc_lo got=%b want=1", tc_lo_w); end
    total++; if (tc_hi_w !== 1'b0) begin bad++; $display("FAIL reset_tc_hi got=%b want=0", tc_hi_w); end
    total++; if (q_s !== 4'd0 || q_m !== 4'd0) begin
      bad++; $display("FAIL reset_q_other got=%0d/%0d want=0/0", q_s, q_m);
    end
  endtask

  task automatic test_wrap_up();
    int exp_q;
    e = 1'b1; d = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      exp_q = i % 10;
      total++; if (q_w !== 4'(exp_q)) begin bad++; $display("FAIL up_q[%0d] got=%0d want=%0d", i, q_w, exp_q); end
      total++; if (co_w !== (exp_q == 9)) begin bad++; $display("FAIL up_co[%0d] got=%b want=%b", i, co_w, exp_q == 9); end
      total++; if (ovf_w !== (i >= 10)) begin bad++; $display("FAIL up_ovf[%0d] got=%b want=%b", i, ovf_w, i >= 10); end
      tick();
    end
    idle();
  endtask

  task automatic test_saturate();
    load = 1'b1; ld_val = 4'd8;
    tick();
    load = 1'b0; e = 1'b1; d = 1'b1;
    #1;
    total++; if (q_s !== 4'd8 || ovf_s !== 1'b0 || co_s !== 1'b0) begin
      bad++; $display("FAIL sat_load q=%0d ovf=%b co=%b want 8/0/0", q_s, ovf_s, co_s);
    end
    tick();
    total++; if (q_s !== 4'd9 || co_s !== 1'b1 || ovf_s !== 1'b0 || tc_hi_s !== 1'b1) begin
      bad++; $display("FAIL sat_up1 q=%0d co=%b ovf=%b tc_hi=%b want 9/1/0/1", q_s, co_s, ovf_s, tc_hi_s);
    end
    tick();
    total++; if (q_s !== 4'd9 || co_s !== 1'b1 || ovf_s !== 1'b1) begin
      bad++; $display("FAIL sat_up2 q=%0d co=%b ovf=%b want 9/1/1", q_s, co_s, ovf_s);
    end
    tick();
    d = 1'b0;
    #1;
    total++; if (q_s !== 4'd9 || ovf_s !== 1'b1 || co_s !== 1'b0) begin
      bad++; $display("FAIL sat_up3 q=%0d ovf=%b co=%b want 9/1/0", q_s, ovf_s, co_s);
    end
    tick();
    total++; if (q_s !== 4'd8 || ovf_s !== 1'b1) begin
      bad++; $display("FAIL sat_dn1 q=%0d ovf=%b want 8/1", q_s, ovf_s);
    end
    tick();
    total++; if (q_s !== 4'd7 || ovf_s !== 1'b1 || tc_lo_s !== 1'b0) begin
      bad++; $display("FAIL sat_dn2 q=%0d ovf=%b tc_lo=%b want 7/1/0", q_s, ovf_s, tc_lo_s);
    end
    idle();
  endtask

  task automatic test_wrap_down();
    load = 1'b1; ld_val = 4'd0;
    tick();
    load = 1'b0; e = 1'b1; d = 1'b0;
    #1;
    total++; if (q_w !== 4'd0 || ovf_w !== 1'b0 || co_w !== 1'b1) begin
      bad++; $display("FAIL dn_start q=%0d ovf=%b co=%b want 0/0/1", q_w, ovf_w, co_w);
    end
    tick();
    total++; if (q_w !== 4'd9 || tc_hi_w !== 1'b1 || ovf_w !== 1'b1) begin
      bad++; $display("FAIL dn_wrap q=%0d tc_hi=%b ovf=%b want 9/1/1", q_w, tc_hi_w, ovf_w);
    end
    tick();
    total++; if (q_w !== 4'd8 || ovf_w !== 1'b1) begin
      bad++; $display("FAIL dn_next q=%0d ovf=%b want 8/1", q_w, ovf_w);
    end
    idle();
  endtask

  task automatic test_load_clamp();
    load = 1'b1; ld_val = 4'd12;
    tick();
    total++; if (q_w !== 4'd9 || ovf_w !== 1'b1 || tc_hi_w !== 1'b1) begin
      bad++; $display("FAIL load_clamp q=%0d ovf=%b tc_hi=%b want 9/1/1", q_w, ovf_w, tc_hi_w);
    end
    ld_val = 4'd3;
    tick();
    total++; if (q_w !== 4'd3 || ovf_w !== 1'b0) begin
      bad++; $display("FAIL load_in_range q=%0d ovf=%b want 3/0", q_w, ovf_w);
    end
    load = 1'b0;
    tick();
    total++; if (q_w !== 4'd3 || ovf_w !== 1'b0) begin
      bad++; $display("FAIL hold q=%0d ovf=%b want 3/0", q_w, ovf_w);
    end
  endtask

  task automatic test_priority();
    load = 1'b1; ld_val = 4'd5;
    tick();
    load = 1'b0;
    pre = 1'b1; load = 1'b1; ld_val = 4'd2; e = 1'b1; d = 1'b1;
    #1;
    total++; if (co_w !== 1'b0) begin bad++; $display("FAIL prio_co_pre got=%b want=0", co_w); end
    tick();
    total++; if (q_w !== 4'd9 || ovf_w !== 1'b0) begin
      bad++; $display("FAIL prio_pre q=%0d ovf=%b want 9/0", q_w, ovf_w);
    end
    total++; if (co_w !== 1'b0) begin bad++; $display("FAIL prio_co_pre_tc got=%b want=0", co_w); end
    pre = 1'b0;
    #1;
    total++; if (co_w !== 1'b0) begin bad++; $display("FAIL prio_co_load got=%b want=0", co_w); end
    load = 1'b0;
    #1;
    total++; if (co_w !== 1'b1) begin bad++; $display("FAIL prio_co_free got=%b want=1", co_w); end
    clr = 1'b1; pre = 1'b1; e = 1'b0;
    #1;
    total++; if (co_w !== 1'b0) begin bad++; $display("FAIL prio_co_clr got=%b want=0", co_w); end
    tick();
    total++; if (q_w !== 4'd0 || ovf_w !== 1'b0) begin
      bad++; $display("FAIL prio_clr q=%0d ovf=%b want 0/0", q_w, ovf_w);
    end
    idle();
  endtask

  task automatic test_mod16();
    load = 1'b1; ld_val = 4'd15;
    tick();
    load = 1'b0; e = 1'b1; d = 1'b1;
    #1;
    total++; if (q_m !== 4'd15 || tc_hi_m !== 1'b1 || co_m !== 1'b1) begin
      bad++; $display("FAIL m16_top q=%0d tc_hi=%b co=%b want 15/1/1", q_m, tc_hi_m, co_m);
    end
    tick();
    total++; if (q_m !== 4'd0 || ovf_m !== 1'b1) begin
      bad++; $display("FAIL m16_wrap q=%0d ovf=%b want 0/1", q_m, ovf_m);
    end
    e = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (q_m !== 4'd0 || tc_lo_m !== 1'b1 || co_m !== 1'b0) begin
        bad++; $display("FAIL m16_hold[%0d] q=%0d tc_lo=%b co=%b want 0/1/0", i, q_m, tc_lo_m, co_m);
      end
    end
    idle();
  endtask

  initial begin
    tick();
    test_reset();
    test_wrap_up();
    test_saturate();
    test_wrap_down();
    test_load_clamp();
    test_priority();
    test_mod16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_updown_counter_mod

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
- Parametrised synchronous up/down counter with modulus, wrap/saturate mode, synchronous preset/clear/load and terminal-count flags.
- Next-generation counter for the stack/queue datapath: a single instance serves as stack pointer (saturate mode) or queue read/write pointer (wrap mode, MODULUS = depth).
- Behavioural RTL, not a chain of 1-bit cells.

Parameters:
- WIDTH, 8: counter width in bits.
- MODULUS, 256: count range 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH; elaboration error otherwise.
- SATURATE, 0: 0 = wrap at the ends of the range; 1 = hold at the ends.
- PRESET_VAL, MODULUS-1: value forced by Pre. Must be < MODULUS.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- Clr  input  1  reset: synchronous, active-high; clears Q to 0.
- Pre  input  1  synchronous preset of Q to PRESET_VAL.
- LOAD  input  1  synchronous parallel load of IN.
- E  input  1  count enable.
- D  input  1  direction: 1 = up, 0 = down.
- IN  input  WIDTH  parallel load value.
- Q  output  WIDTH  count value (registered).
- TC_HI  output  1  Q == MODULUS-1 (combinational from Q).
- TC_LO  output  1  Q == 0 (combinational from Q).
- CO  output  1  carry/borrow: a step is attempted at the terminal value this cycle (combinational).
- OVF  output  1  sticky out-of-range flag (registered).

Behaviour:
- Clock and reset: single clock CLK. Clr is synchronous, active-high.
- Priority, evaluated each rising edge: Clr > Pre > LOAD > E > hold.
- Clr: Q <= 0, OVF <= 0.
- Pre: Q <= PRESET_VAL, OVF <= 0.
- LOAD:
  - IN < MODULUS: Q <= IN, OVF <= 0.
  - IN >= MODULUS: Q <= MODULUS-1 (clamped), OVF <= 1.
- E with D=1 (up):
  - Q < MODULUS-1: Q <= Q+1.
  - Q == MODULUS-1: SATURATE=0 gives Q <= 0; SATURATE=1 holds Q. OVF <= 1 in both cases.
- E with D=0 (down):
  - Q > 0: Q <= Q-1.
  - Q == 0: SATURATE=0 gives Q <= MODULUS-1; SATURATE=1 holds Q. OVF <= 1 in both cases.
- E=0, no control asserted: Q and OVF hold.
- OVF is sticky. Only Clr, Pre or an in-range LOAD clears it; counting never clears it.
- CO = E & ~Clr & ~Pre & ~LOAD & ((D & TC_HI) | (~D & TC_LO)).
  - Asserted in the same cycle as the terminal step; Q changes on the following edge.
  - Asserted in both modes. Intended for cascading and for full/empty detection.
- Latency: one cycle from any control input to Q. Flags follow Q combinationally, so they are valid in the same cycle as Q.
- Output values after Clr: Q=0, OVF=0, TC_LO=1, TC_HI=0 (MODULUS >= 2), CO follows its inputs.
- No reset is required before first use for correct step arithmetic, but Q is undefined until the first Clr, Pre or LOAD.
- Arithmetic is WIDTH bits wide. When MODULUS == 2**WIDTH, wrap is natural overflow; the implementation must still use an explicit compare so that non-power-of-two moduli work.
- Simultaneous controls: the highest-priority control wins and all lower ones are ignored, e.g. Pre+LOAD+E gives Q=PRESET_VAL and CO=0.
- Clr asserted mid-count overrides the step on that edge; counting resumes from 0 on the next enabled cycle.

Decomposition:
- Shared package counter_pkg:
  - mode constants CNT_WRAP=0, CNT_SAT=1;
  - direction constants DIR_UP=1, DIR_DN=0.
- One combinational sub-module, counter_step.
  - Inputs: Q, D, SATURATE, MODULUS.
  - Outputs: next value and at-terminal flag.
- The top level holds the register, priority mux, OVF and flags.

Test Plan:
All cases use WIDTH=4, MODULUS=10 unless noted.
1. Clr=1 for one edge, then E=1, D=1 for 12 cycles, SATURATE=0 -> Q = 0,1,...,9,0,1. CO=1 only in the cycle Q=9. OVF=1 from the edge after CO.
2. SATURATE=1: LOAD IN=8, then up 3 cycles -> Q = 8,9,9,9. CO=1 while Q=9 and E=1. OVF=1 after the first blocked step. Then down 2 cycles -> Q = 8,7 with OVF still 1.
3. Wrap mode: LOAD IN=0, then D=0, E=1 -> Q=9, TC_HI=1, OVF=1. Next cycle -> Q=8.
4. LOAD IN=12 -> Q=9, OVF=1. LOAD IN=3 -> Q=3, OVF=0.
5. Priority: Q=5; assert Pre, LOAD (IN=2) and E in the same cycle -> Q=9, CO=0. Next cycle assert Clr and Pre together -> Q=0, OVF=0.
6. MODULUS=16, SATURATE=0: Q=15, up -> Q=0 with CO=1 on the prior cycle. Q=0, E=0 for 5 cycles -> Q holds 0 and TC_LO=1 throughout.
